// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the rv32i pipeline: turns EX/MEM load/store controls into a
// valid/grant/rvalid data-memory transaction and registers the MEM/WB entry.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_rs2_data_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_regwrite_i,
  input  logic        ex_memread_i,
  input  logic        ex_memwrite_i,
  input  logic [2:0]  ex_width_i,
  input  logic        ex_wb_sel_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        memwb_valid_o,
  output logic [31:0] memwb_alu_result_o,
  output logic [31:0] memwb_mem_data_o,
  output logic [4:0]  memwb_rd_addr_o,
  output logic        memwb_regwrite_o,
  output logic        memwb_wb_sel_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;

  logic [31:0] op_addr_q, op_wdata_q;
  logic [3:0]  op_be_q;
  logic        op_load_q, op_regwrite_q, op_wb_sel_q;
  logic [2:0]  op_width_q;
  logic [4:0]  op_rd_q;

  logic        is_mem, is_load, width_ok, align_ok, legal, timeout_hit;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem   = ex_valid_i & (ex_memread_i | ex_memwrite_i);
  assign is_load  = ex_memread_i;
  assign width_ok = is_load ? (ex_width_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                            : (ex_width_i inside {3'b000, 3'b001, 3'b010});
  assign legal    = width_ok & align_ok;

  always_comb begin
    align_ok = 1'b1;
    be_in    = 4'b1111;
    wdata_in = ex_rs2_data_i;
    case (ex_width_i[1:0])
      2'b00: begin
        be_in    = 4'b0001 << ex_alu_result_i[1:0];
        wdata_in = {4{ex_rs2_data_i[7:0]}};
      end
      2'b01: begin
        align_ok = ~ex_alu_result_i[0];
        be_in    = 4'b0011 << {ex_alu_result_i[1], 1'b0};
        wdata_in = {2{ex_rs2_data_i[15:0]}};
      end
      2'b10: align_ok = (ex_alu_result_i[1:0] == 2'b00);
      default: ;
    endcase
  end

  // Lane selection uses the captured address; the response belongs to the captured op.
  always_comb begin
    case (op_addr_q[1:0])
      2'b00:   ld_byte = dmem_rdata_i[7:0];
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = op_addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (op_width_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  assign timeout_hit  = (state_q == WAIT) && !dmem_rvalid_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = ~op_load_q;
  assign dmem_addr_o  = {op_addr_q[31:2], 2'b00};
  assign dmem_be_o    = op_be_q;
  assign dmem_wdata_o = op_wdata_q;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: if (is_mem && legal) begin
        stall_o = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) begin
          state_d = op_load_q ? WAIT : IDLE;
          stall_o = op_load_q;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i || timeout_hit) begin
          state_d = IDLE;
          stall_o = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_addr_q     <= '0;
      op_wdata_q    <= '0;
      op_be_q       <= '0;
      op_load_q     <= 1'b0;
      op_width_q    <= '0;
      op_rd_q       <= '0;
      op_regwrite_q <= 1'b0;
      op_wb_sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == REQ && dmem_gnt_i)
        cnt_q <= '0;
      else if (state_q == WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (state_q == IDLE && state_d == REQ) begin
        op_addr_q     <= ex_alu_result_i;
        op_wdata_q    <= is_load ? 32'h0 : wdata_in;
        op_be_q       <= be_in;
        op_load_q     <= is_load;
        op_width_q    <= ex_width_i;
        op_rd_q       <= ex_rd_addr_i;
        op_regwrite_q <= ex_regwrite_i;
        op_wb_sel_q   <= ex_wb_sel_i;
      end
    end
  end

  // MEM/WB register: bubbles by default, written only on a completion cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      memwb_valid_o      <= 1'b0;
      memwb_alu_result_o <= '0;
      memwb_mem_data_o   <= '0;
      memwb_rd_addr_o    <= '0;
      memwb_regwrite_o   <= 1'b0;
      memwb_wb_sel_o     <= 1'b0;
      misalign_o         <= 1'b0;
      bus_err_o          <= 1'b0;
    end else begin
      memwb_valid_o    <= 1'b0;
      memwb_regwrite_o <= 1'b0;
      misalign_o       <= 1'b0;
      bus_err_o        <= 1'b0;
      case (state_q)
        IDLE: if (ex_valid_i && !(is_mem && legal)) begin
          memwb_valid_o      <= 1'b1;
          memwb_alu_result_o <= ex_alu_result_i;
          memwb_mem_data_o   <= '0;
          memwb_rd_addr_o    <= ex_rd_addr_i;
          memwb_wb_sel_o     <= ex_wb_sel_i;
          memwb_regwrite_o   <= ex_regwrite_i & ~is_mem;
          misalign_o         <= is_mem;
        end
        REQ: if (dmem_gnt_i && !op_load_q) begin
          memwb_valid_o      <= 1'b1;
          memwb_alu_result_o <= op_addr_q;
          memwb_mem_data_o   <= '0;
          memwb_rd_addr_o    <= op_rd_q;
          memwb_wb_sel_o     <= op_wb_sel_q;
        end
        WAIT: if (dmem_rvalid_i || timeout_hit) begin
          memwb_valid_o      <= 1'b1;
          memwb_alu_result_o <= op_addr_q;
          memwb_mem_data_o   <= dmem_rvalid_i ? load_data : 32'h0;
          memwb_rd_addr_o    <= op_rd_q;
          memwb_wb_sel_o     <= op_wb_sel_q;
          memwb_regwrite_o   <= dmem_rvalid_i & op_regwrite_q;
          bus_err_o          <= ~dmem_rvalid_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a transaction-level model predicts each MEM/WB entry
// and bus request, and a negedge monitor compares the DUT against it every cycle.
module tb_mem_stage_lsu;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_regwrite_i, ex_memread_i, ex_memwrite_i, ex_wb_sel_i;
  logic [31:0] ex_alu_result_i, ex_rs2_data_i;
  logic [4:0]  ex_rd_addr_i;
  logic [2:0]  ex_width_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        memwb_valid_o, memwb_regwrite_o, memwb_wb_sel_o, misalign_o, bus_err_o;
  logic [31:0] memwb_alu_result_o, memwb_mem_data_o;
  logic [4:0]  memwb_rd_addr_o;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_alu_result_i(ex_alu_result_i), .ex_rs2_data_i(ex_rs2_data_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
    .ex_memwrite_i(ex_memwrite_i), .ex_width_i(ex_width_i), .ex_wb_sel_i(ex_wb_sel_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .memwb_valid_o(memwb_valid_o), .memwb_alu_result_o(memwb_alu_result_o),
    .memwb_mem_data_o(memwb_mem_data_o), .memwb_rd_addr_o(memwb_rd_addr_o),
    .memwb_regwrite_o(memwb_regwrite_o), .memwb_wb_sel_o(memwb_wb_sel_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        rw;
    logic        wbs;
    logic        mis;
    logic        berr;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_exp, mon_act;
  logic [68:0] exp_req;
  bit          exp_req_valid = 1'b0;
  bit          chk_en = 1'b0;
  bit          seen_req;
  logic [31:0] last_req_addr, last_req_wdata;
  logic [3:0]  last_req_be;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  function automatic int accSize(input bit ld, input logic [2:0] w);
    int r;
    r = 0;
    if (ld) begin
      if (w == 3'd0 || w == 3'd4) r = 1;
      else if (w == 3'd1 || w == 3'd5) r = 2;
      else if (w == 3'd2) r = 4;
    end else begin
      if (w == 3'd0) r = 1;
      else if (w == 3'd1) r = 2;
      else if (w == 3'd2) r = 4;
    end
    return r;
  endfunction

  function automatic logic [31:0] loadValue(input logic [2:0] w, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] s, v;
    int size;
    size = accSize(1'b1, w);
    s = rdata >> (8 * (addr % 32'd4));
    v = rdata;
    if (size == 1) begin
      v = s & 32'hFF;
      if (!w[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = s & 32'hFFFF;
      if (!w[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Present one EX/MEM entry, predict its outcome, then play the bus side until it retires.
  task automatic applyStimulus(input bit v, input logic [31:0] alu, input logic [31:0] rs2,
                               input logic [4:0] rd, input bit rw, input bit mr, input bit mw,
                               input logic [2:0] w, input bit wbs, input int gnt_wait,
                               input bit give_rv, input int rv_wait, input logic [31:0] rdata,
                               output int cycles);
    int size, be_int, req_cycles, wait_cycles;
    bit done, r, g, rv, waiting;
    logic [31:0] wd;
    wb_t e;
    ex_valid_i = v; ex_alu_result_i = alu; ex_rs2_data_i = rs2; ex_rd_addr_i = rd;
    ex_regwrite_i = rw; ex_memread_i = mr; ex_memwrite_i = mw; ex_width_i = w;
    ex_wb_sel_i = wbs; dmem_rdata_i = rdata;
    seen_req = 1'b0;
    size = accSize(mr, w);
    if (v && (mr || mw)) begin
      if (size != 0 && (alu % 32'(size)) == 0) begin
        be_int = ((1 << size) - 1) << int'(alu % 32'd4);
        if (size == 1)      wd = {24'h0, rs2[7:0]} * 32'h0101_0101;
        else if (size == 2) wd = {16'h0, rs2[15:0]} * 32'h0001_0001;
        else                wd = rs2;
        if (mr) wd = 32'h0;
        exp_req = {!mr, alu & 32'hFFFF_FFFC, be_int[3:0], wd};
        exp_req_valid = 1'b1;
        if (!mr)          e = '{alu, 32'h0, rd, 1'b0, wbs, 1'b0, 1'b0};
        else if (give_rv) e = '{alu, loadValue(w, alu, rdata), rd, rw, wbs, 1'b0, 1'b0};
        else              e = '{alu, 32'h0, rd, 1'b0, wbs, 1'b0, 1'b1};
      end else begin
        e = '{alu, 32'h0, rd, 1'b0, wbs, 1'b1, 1'b0};
      end
      exp_q.push_back(e);
    end else if (v) begin
      exp_q.push_back('{alu, 32'h0, rd, rw, wbs, 1'b0, 1'b0});
    end
    cycles = 0; req_cycles = 0; wait_cycles = 0; done = 1'b0; waiting = 1'b0;
    while (!done && cycles < 100) begin
      dmem_gnt_i    = dmem_req_o && (req_cycles >= gnt_wait);
      dmem_rvalid_i = waiting && give_rv && (wait_cycles >= rv_wait);
      @(negedge clk_i);
      done = !stall_o; r = dmem_req_o; g = dmem_gnt_i; rv = dmem_rvalid_i;
      if (r) seen_req = 1'b1;
      @(posedge clk_i);
      #1;
      cycles++;
      if (r) begin
        req_cycles++;
        if (g) begin
          exp_req_valid = 1'b0;
          if (mr) waiting = 1'b1;
        end
      end else if (waiting && !rv) begin
        wait_cycles++;
      end
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    ex_valid_i = 1'b0; ex_memread_i = 1'b0; ex_memwrite_i = 1'b0;
    checkOutput("retire_within_bound", {31'h0, done}, 32'h1);
  endtask

  // Monitor: every MEM/WB entry and every bus request is checked against the model.
  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      if (memwb_valid_o) begin
        checks++;
        mon_act = '{memwb_alu_result_o, memwb_mem_data_o, memwb_rd_addr_o, memwb_regwrite_o,
                    memwb_wb_sel_o, misalign_o, bus_err_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL memwb_unexpected actual=%h required=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("[TB] FAIL memwb_entry actual=%h required=%h", mon_act, mon_exp);
          end
        end
      end else if (misalign_o || bus_err_o) begin
        checks++;
        errors++;
        $display("[TB] FAIL pulse_without_valid actual=%b%b required=00", misalign_o, bus_err_o);
      end
      if (dmem_req_o) begin
        checks++;
        last_req_addr = dmem_addr_o; last_req_be = dmem_be_o; last_req_wdata = dmem_wdata_o;
        if (!exp_req_valid || {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== exp_req) begin
          errors++;
          $display("[TB] FAIL dmem_request actual=%h required=%h valid=%0d",
                   {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, exp_req, exp_req_valid);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    ex_valid_i = 0; ex_alu_result_i = 0; ex_rs2_data_i = 0; ex_rd_addr_i = 0;
    ex_regwrite_i = 0; ex_memread_i = 0; ex_memwrite_i = 0; ex_width_i = 0; ex_wb_sel_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_req", {31'h0, dmem_req_o}, 32'h0);
    checkOutput("reset_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("reset_memwb_valid", {31'h0, memwb_valid_o}, 32'h0);
    checkOutput("reset_addr", dmem_addr_o, 32'h0);
    checkOutput("reset_pulses", {30'h0, misalign_o, bus_err_o}, 32'h0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    checkOutput("model_lb", loadValue(3'b000, 32'h2002, 32'h0080_0000), 32'hFFFF_FF80);
    checkOutput("model_lbu", loadValue(3'b100, 32'h2002, 32'h0080_0000), 32'h0000_0080);

    $display("[TB] ALU pass-through");
    applyStimulus(1, 32'h0000_00AA, 0, 5, 1, 0, 0, 3'b010, 0, 0, 0, 0, 0, cyc);
    checkOutput("alu_cycles", cyc, 1);
    checkOutput("alu_result", memwb_alu_result_o, 32'hAA);
    checkOutput("alu_rd", {27'h0, memwb_rd_addr_o}, 5);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, cyc);
    checkOutput("bubble_valid", {31'h0, memwb_valid_o}, 0);

    $display("[TB] SB with delayed grant");
    applyStimulus(1, 32'h1003, 32'h1234_56F0, 9, 1, 0, 1, 3'b000, 0, 2, 0, 0, 0, cyc);
    checkOutput("sb_cycles", cyc, 4);
    checkOutput("sb_addr", last_req_addr, 32'h1000);
    checkOutput("sb_be", {28'h0, last_req_be}, 32'h8);
    checkOutput("sb_wdata", last_req_wdata, 32'hF0F0_F0F0);
    checkOutput("sb_regwrite", {31'h0, memwb_regwrite_o}, 0);

    applyStimulus(1, 32'h1006, 32'hAAAA_BEEF, 3, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0, cyc);
    checkOutput("sh_be", {28'h0, last_req_be}, 32'hC);
    checkOutput("sh_wdata", last_req_wdata, 32'hBEEF_BEEF);
    applyStimulus(1, 32'h1008, 32'hCAFE_F00D, 3, 0, 0, 1, 3'b010, 0, 1, 0, 0, 0, cyc);
    checkOutput("sw_cycles", cyc, 3);

    $display("[TB] Loads");
    applyStimulus(1, 32'h2002, 0, 10, 1, 1, 0, 3'b000, 1, 0, 1, 0, 32'h0080_0000, cyc);
    checkOutput("lb_cycles", cyc, 3);
    checkOutput("lb_data", memwb_mem_data_o, 32'hFFFF_FF80);
    applyStimulus(1, 32'h2002, 0, 11, 1, 1, 0, 3'b100, 1, 0, 1, 0, 32'h0080_0000, cyc);
    checkOutput("lbu_data", memwb_mem_data_o, 32'h0000_0080);
    applyStimulus(1, 32'h2002, 0, 12, 1, 1, 0, 3'b001, 1, 1, 1, 2, 32'h8001_1234, cyc);
    checkOutput("lh_data", memwb_mem_data_o, 32'hFFFF_8001);
    applyStimulus(1, 32'h2002, 0, 13, 1, 1, 0, 3'b101, 1, 0, 1, 0, 32'h8001_1234, cyc);
    checkOutput("lhu_data", memwb_mem_data_o, 32'h0000_8001);
    applyStimulus(1, 32'h2004, 0, 14, 1, 1, 1, 3'b010, 1, 0, 1, 3, 32'h1357_9BDF, cyc);
    checkOutput("lw_cycles", cyc, 6);

    $display("[TB] Misaligned and illegal");
    applyStimulus(1, 32'h2001, 0, 15, 1, 1, 0, 3'b001, 1, 0, 1, 0, 0, cyc);
    checkOutput("lh_mis_cycles", cyc, 1);
    checkOutput("lh_mis_noreq", {31'h0, seen_req}, 0);
    checkOutput("lh_mis_pulse", {31'h0, misalign_o}, 1);
    checkOutput("lh_mis_regwrite", {31'h0, memwb_regwrite_o}, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, cyc);
    checkOutput("mis_pulse_end", {31'h0, misalign_o}, 0);
    applyStimulus(1, 32'h1002, 32'h1, 4, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0, cyc);
    applyStimulus(1, 32'h1000, 32'h1, 4, 0, 0, 1, 3'b011, 0, 0, 0, 0, 0, cyc);
    applyStimulus(1, 32'h1000, 32'h1, 4, 1, 1, 0, 3'b110, 0, 0, 1, 0, 0, cyc);
    checkOutput("illegal_noreq", {31'h0, seen_req}, 0);

    $display("[TB] Load timeout");
    applyStimulus(1, 32'h3000, 0, 20, 1, 1, 0, 3'b010, 1, 0, 0, 0, 32'hFFFF_FFFF, cyc);
    checkOutput("to_cycles", cyc, TO + 2);
    checkOutput("to_bus_err", {31'h0, bus_err_o}, 1);
    checkOutput("to_data", memwb_mem_data_o, 0);
    applyStimulus(1, 32'h55, 0, 6, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, cyc);
    checkOutput("after_to_cycles", cyc, 1);
    checkOutput("after_to_bus_err", {31'h0, bus_err_o}, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, cyc);

    $display("[TB] Reset during WAIT");
    chk_en = 1'b0;
    ex_valid_i = 1; ex_alu_result_i = 32'h3000; ex_memread_i = 1; ex_width_i = 3'b010;
    ex_rd_addr_i = 7; ex_regwrite_i = 1; ex_wb_sel_i = 1;
    @(posedge clk_i);
    #1;
    dmem_gnt_i = 1;
    @(posedge clk_i);
    #1;
    dmem_gnt_i = 0;
    checkOutput("rst_pre_stall", {31'h0, stall_o}, 1);
    #2;
    rst_ni = 1'b0; ex_valid_i = 0; ex_memread_i = 0;
    #1;
    checkOutput("rst_req_drop", {31'h0, dmem_req_o}, 0);
    checkOutput("rst_stall_drop", {31'h0, stall_o}, 0);
    checkOutput("rst_addr_clear", dmem_addr_o, 0);
    checkOutput("rst_be_clear", {28'h0, dmem_be_o}, 0);
    checkOutput("rst_memwb_clear", {memwb_alu_result_o[26:0], memwb_rd_addr_o}, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_q.delete();
    exp_req_valid = 1'b0;
    dmem_rdata_i = 32'hDEAD_BEEF;
    dmem_rvalid_i = 1;
    @(posedge clk_i);
    #1;
    dmem_rvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_late_rvalid", {31'h0, memwb_valid_o}, 0);
      @(posedge clk_i);
      #1;
    end
    chk_en = 1'b1;
    applyStimulus(1, 32'h77, 0, 8, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, cyc);
    checkOutput("post_rst_alu", memwb_alu_result_o, 32'h77);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, cyc);
    @(posedge clk_i);
    #1;
    checkOutput("model_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
